// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared single-port memory. Ownership is registered,
// ties go round-robin, and a hold counter bounds how long one owner can starve the other.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic [1:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        owner
);

  // Handshake: a master presents cmd/addr/wdata and holds them until it sees its gnt
  // high; one beat transfers in every cycle where gnt is high; an accepted MREAD returns
  // data on rdata with that master's rvalid high in exactly the following cycle.

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } own_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  own_t       owner_q, owner_d;
  own_t       last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic       m0_rvalid_q, m0_rvalid_d;
  logic       m1_rvalid_q, m1_rvalid_d;

  logic req0, req1;
  logic req_own, req_oth;
  own_t other;

  // The illegal 11 encoding has both bits set, so it never counts as a request.
  assign req0 = m0_cmd[0] ^ m0_cmd[1];
  assign req1 = m1_cmd[0] ^ m1_cmd[1];

  assign owner     = owner_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign rdata     = mem_rdata;

  always_comb begin
    m0_gnt    = (owner_q == OWN_M0) && req0;
    m1_gnt    = (owner_q == OWN_M1) && req1;
    mem_cmd   = CMD_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner_q)
      OWN_M0: begin
        mem_cmd   = req0 ? m0_cmd : CMD_NONE;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      OWN_M1: begin
        mem_cmd   = req1 ? m1_cmd : CMD_NONE;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    req_own     = (owner_q == OWN_M0) ? req0 : req1;
    req_oth     = (owner_q == OWN_M0) ? req1 : req0;
    other       = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;
    m0_rvalid_d = m0_gnt && (m0_cmd == CMD_READ);
    m1_rvalid_d = m1_gnt && (m1_cmd == CMD_READ);
    case (owner_q)
      OWN_M0, OWN_M1: begin
        if (!req_own) begin
          // Release hands straight to a waiting master so the bus never idles.
          owner_d = req_oth ? other : OWN_NONE;
          if (req_oth) last_d = other;
          hold_d = '0;
        end else if (req_oth) begin
          if (hold_q == HOLD_LAST) begin
            owner_d = other;
            last_d  = other;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      default: begin
        // Idle: a lone requester wins; on a tie the master not granted last wins.
        if (req0 && (!req1 || last_q != OWN_M0)) owner_d = OWN_M0;
        else if (req1)                           owner_d = OWN_M1;
        else                                     owner_d = OWN_NONE;
        if (req0 || req1) last_d = owner_d;
        hold_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= OWN_M1;
      hold_q      <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a behavioural RAM, two master drivers, a read-data
// scoreboard and a grant/ownership trace compared against hand-derived sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m0_cmd = '0, m1_cmd = '0;
  logic [8:0]  m0_addr = '0, m1_addr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [1:0]  mem_cmd, owner;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, rdata;
  logic [15:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [3:0]  log_q[$];
  logic        log_en = 1'b0;
  logic [15:0] ram [512];

  mem_bus_arbiter #(.ADDR_W(9), .DATA_W(16), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .owner(owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_val(input logic [8:0] a);
    return 16'hA000 ^ {7'd0, a};
  endfunction

  // ---------------- RAM model ----------------
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = init_val(9'(i));
  end

  always @(posedge clk) begin
    if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and trace monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) check_val("rv_both", 32'(m0_rvalid & m1_rvalid), 32'd0);
    if (m0_rvalid) begin
      check_val("rv0_expected", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) check_val("rdata0", 32'(rdata), 32'(exp_q0.pop_front()));
    end
    if (m1_rvalid) begin
      check_val("rv1_expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) check_val("rdata1", 32'(rdata), 32'(exp_q1.pop_front()));
    end
    if (log_en) log_q.push_back({owner, m1_gnt, m0_gnt});
  end

  // ---------------- drivers ----------------
  task automatic drive_m(input int m, input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd);
    if (m == 0) begin m0_cmd = cmd; m0_addr = a; m0_wdata = wd; end
    else        begin m1_cmd = cmd; m1_addr = a; m1_wdata = wd; end
  endtask

  // Entered and left at posedge+1; each beat is held until its grant is seen.
  task automatic m_burst(input int m, input int n, input logic [1:0] cmd,
                         input logic [8:0] base, input logic [15:0] wd);
    for (int i = 0; i < n; i++) begin
      logic [8:0] a;
      logic       g;
      int         w;
      a = base + 9'(i);
      drive_m(m, cmd, a, wd + 16'(i));
      if (cmd == 2'b01) begin
        if (m == 0) exp_q0.push_back(init_val(a));
        else        exp_q1.push_back(init_val(a));
      end
      w = 0;
      g = 1'b0;
      while (!g && w <= 40) begin
        @(negedge clk);
        g = (m == 0) ? m0_gnt : m1_gnt;
        w++;
        if (!g) begin @(posedge clk); #1; end
      end
      check_val(m == 0 ? "m0_gnt_seen" : "m1_gnt_seen", 32'(g), 32'd1);
      @(posedge clk); #1;
    end
    drive_m(m, 2'b00, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_m(0, 2'b00, '0, '0);
    drive_m(1, 2'b00, '0, '0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp3 [6];
    int n, w, n1;
    exp3 = '{4'h0, 4'h5, 4'h4, 4'hA, 4'h8, 4'h0};

    // Reset state while reset is held
    #2;
    check_val("rst_owner", 32'(owner), 32'd0);
    check_val("rst_gnt0", 32'(m0_gnt), 32'd0);
    check_val("rst_gnt1", 32'(m1_gnt), 32'd0);
    check_val("rst_mem_cmd", 32'(mem_cmd), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_rvalids", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_owner", 32'(owner), 32'd0);
      check_val("idle_gnts", 32'({m1_gnt, m0_gnt}), 32'd0);
      check_val("idle_mem_cmd", 32'(mem_cmd), 32'd0);
    end

    // Single M0 read: granted the cycle after it appears, data the cycle after that
    @(posedge clk); #1;
    drive_m(0, 2'b01, 9'h005, 16'h0);
    exp_q0.push_back(init_val(9'h005));
    @(negedge clk);
    check_val("rd_lat_owner", 32'(owner), 32'd0);
    check_val("rd_lat_gnt0", 32'(m0_gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rd_owner", 32'(owner), 32'd1);
    check_val("rd_gnt0", 32'(m0_gnt), 32'd1);
    check_val("rd_mem_addr", 32'(mem_addr), 32'h005);
    check_val("rd_mem_cmd", 32'(mem_cmd), 32'd1);
    @(posedge clk); #1;
    drive_m(0, 2'b00, '0, '0);
    @(negedge clk);
    check_val("rd_rvalid0", 32'(m0_rvalid), 32'd1);
    repeat (2) @(negedge clk);
    check_val("rd_owner_released", 32'(owner), 32'd0);

    // Tie right after reset: M0 wins, ownership hands to M1 without passing through NONE
    do_reset();
    log_q.delete();
    log_en = 1'b1;
    fork
      m_burst(0, 1, 2'b01, 9'h010, 16'h0);
      m_burst(1, 1, 2'b10, 9'h020, 16'hBEEF);
    join
    repeat (2) @(negedge clk);
    #1 log_en = 1'b0;
    check_val("tie_log_len", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check_val("tie_trace", 32'(log_q[i]), 32'(exp3[i]));
    check_val("ram_20", 32'(ram[9'h020]), 32'h0000BEEF);

    // Continuous contention: grants alternate in runs of 4
    do_reset();
    log_q.delete();
    log_en = 1'b1;
    fork
      m_burst(0, 12, 2'b01, 9'h040, 16'h0);
      m_burst(1, 12, 2'b10, 9'h080, 16'h5500);
    join
    log_en = 1'b0;
    check_val("rr_log_len", 32'(log_q.size()), 32'd25);
    for (int i = 0; i < 25 && i < log_q.size(); i++) begin
      logic [1:0] e;
      if (i == 0) e = 2'b00;
      else e = (((i - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      check_val("rr_gnt_run", 32'(log_q[i][1:0]), 32'(e));
    end
    check_val("ram_8b", 32'(ram[9'h08B]), 32'h0000550B);

    // M1 streams alone, then M0 arrives and must win within 4 more M1 beats
    do_reset();
    fork
      m_burst(1, 30, 2'b10, 9'h100, 16'h1200);
      begin
        n = 0; w = 0;
        while (n < 20 && w < 200) begin
          @(negedge clk);
          if (m1_gnt) n++;
          w++;
        end
        check_val("m1_stream_beats", 32'(n), 32'd20);
        @(posedge clk); #1;
        drive_m(0, 2'b01, 9'h0C0, 16'h0);
        exp_q0.push_back(init_val(9'h0C0));
        n1 = 0; w = 0;
        @(negedge clk);
        while (!m0_gnt && w < 40) begin
          if (m1_gnt) n1++;
          w++;
          @(posedge clk); #1;
          @(negedge clk);
        end
        check_val("m0_gnt_after_stream", 32'(m0_gnt), 32'd1);
        check_val("m1_beats_before_m0", 32'(n1), 32'd4);
        @(posedge clk); #1;
        drive_m(0, 2'b00, '0, '0);
      end
    join

    // Illegal M0 command is never granted nor forwarded; M1 reads proceed
    do_reset();
    drive_m(0, 2'b11, 9'h1F0, 16'hDEAD);
    fork
      m_burst(1, 3, 2'b01, 9'h150, 16'h0);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check_val("ill_gnt0", 32'(m0_gnt), 32'd0);
        check_val("ill_mem_cmd_11", 32'(mem_cmd == 2'b11), 32'd0);
        check_val("ill_owner_m0", 32'(owner == 2'b01), 32'd0);
      end
    join
    @(posedge clk); #1;
    drive_m(0, 2'b00, '0, '0);

    // Async reset during a live grant with a read return pending
    do_reset();
    drive_m(0, 2'b01, 9'h1A0, 16'h0);
    w = 0;
    @(negedge clk);
    while (!m0_gnt && w < 10) begin
      w++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check_val("ar_gnt_seen", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    check_val("ar_gnt_live", 32'(m0_gnt), 32'd1);
    check_val("ar_rvalid_pending", 32'(m0_rvalid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("ar_gnt_cleared", 32'(m0_gnt), 32'd0);
    check_val("ar_owner_cleared", 32'(owner), 32'd0);
    check_val("ar_mem_cmd_cleared", 32'(mem_cmd), 32'd0);
    check_val("ar_rvalid_dropped", 32'(m0_rvalid), 32'd0);
    drive_m(0, 2'b00, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("ar_no_reissue", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    end

    check_val("q0_drained", 32'(exp_q0.size()), 32'd0);
    check_val("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
